// File: rtl/ppacc_seq.sv
// ppacc_seq: multi-cycle Baugh-Wooley partial-product accumulator, ROWS rows per cycle
module ppacc_seq #(
  parameter int DW = 12,
  parameter int ROWS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW*DW-1:0] pp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*DW-1:0]  prod,
  output logic             busy
);
  localparam int W = 2*DW;
  localparam int CW = $clog2(DW+1);
  localparam logic [W-1:0] C = (W'(1) << DW) | (W'(1) << (W-1));
  if (DW % ROWS != 0) begin : g_chk
    $error("ppacc_seq: DW must be a multiple of ROWS");
  end
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0] acc, add;
  logic [DW*DW-1:0] ppr;
  logic accept, last;
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign busy = state == ACC;
  assign accept = in_valid && in_ready;
  assign last = cnt == CW'(DW-ROWS);
  always_comb begin
    add = '0;
    for (int k = 0; k < ROWS; k++)
      add = add + (W'(ppr[DW*(int'(cnt)+k) +: DW]) << (int'(cnt)+k));
  end
  always_comb begin
    state_nx = accept ? ACC :
               (state == ACC && last) ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // cnt parks on the last row group so the row select stays in range outside ACC
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      ppr <= '0;
      prod <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        ppr <= pp;
        acc <= C;
        cnt <= '0;
      end else if (state == ACC) begin
        acc <= acc + add;
        cnt <= last ? cnt : cnt + CW'(ROWS);
      end
      if (state == ACC && last) prod <= acc + add;
      out_valid <= state_nx == DONE;
    end
  end
endmodule

// File: tb/tb_ppacc_seq.sv
// tb_ppacc_seq: randomized self-checking bench for ppacc_seq against an integer-multiply model
module tb_ppacc_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [143:0] pp = '0;
  logic in_ready, out_valid, busy;
  logic [23:0] prod;
  logic sw_valid = 1'b0;
  logic [143:0] sw_pp = '0;
  logic [4:0] sw_ir, sw_ov, sw_busy;
  logic [23:0] sw_prod [5];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ppacc_seq #(.DW(12), .ROWS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pp(pp),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .busy(busy)
  );

  for (genvar g = 0; g < 5; g++) begin : g_sw
    localparam int R = g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 4 : g == 3 ? 6 : 12;
    ppacc_seq #(.DW(12), .ROWS(R)) u (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[g]), .pp(sw_pp),
      .out_valid(sw_ov[g]), .out_ready(1'b1), .prod(sw_prod[g]), .busy(sw_busy[g])
    );
  end

  function automatic logic [143:0] mkpp(input logic [11:0] a, input logic [11:0] b);
    logic [143:0] v;
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 12; j++)
        v[12*i+j] = (a[j] & b[i]) ^ ((i == 11) != (j == 11));
    return v;
  endfunction

  function automatic logic [23:0] ref_mul(input logic [11:0] a, input logic [11:0] b);
    logic signed [11:0] sa, sb;
    int p;
    sa = a;
    sb = b;
    p = int'(sa) * int'(sb);
    return p[23:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [11:0] a, input logic [11:0] b, output int lat, output logic [23:0] p);
    int n = 0;
    pp = mkpp(a, b);
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    p = prod;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || prod !== 24'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: ov=%b busy=%b prod=%h ir=%b required 0 0 000000 1", out_valid, busy, prod, in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat = 0;
    pp = mkpp(12'd3, 12'd5);
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_acc: busy=%b ov=%b ir=%b required 1 0 0", busy, out_valid, in_ready);
    end
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4 || prod !== 24'h00000F) begin
      errors++;
      $display("FAIL basic_out: lat=%0d prod=%h required 4 00000f", lat, prod);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || prod !== 24'h00000F) begin
      errors++;
      $display("FAIL basic_idle: ov=%b busy=%b ir=%b prod=%h required 0 0 1 00000f", out_valid, busy, in_ready, prod);
    end
  endtask

  task automatic test_corners();
    logic [11:0] ca [5] = '{12'hFFF, 12'h800, 12'h7FF, 12'h000, 12'h7FF};
    logic [11:0] cb [5] = '{12'hFFF, 12'h800, 12'h800, 12'h800, 12'h7FF};
    logic [23:0] ce [5] = '{24'h000001, 24'h400000, 24'hC00800, 24'h000000, 24'h3FF001};
    int lat;
    logic [23:0] p;
    for (int i = 0; i < 5; i++) begin
      txn(ca[i], cb[i], lat, p);
      checks++;
      if (lat !== 4 || p !== ce[i]) begin
        errors++;
        $display("FAIL corner%0d: lat=%0d prod=%h required 4 %h", i, lat, p, ce[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] held;
    int lat = 0;
    out_ready = 1'b0;
    pp = mkpp(12'hABC, 12'h123);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    held = prod;
    checks++;
    if (held !== ref_mul(12'hABC, 12'h123)) begin
      errors++;
      $display("FAIL bp_prod: prod=%h required %h", held, ref_mul(12'hABC, 12'h123));
    end
    pp = mkpp(12'h111, 12'h222);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || prod !== held || in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: ov=%b prod=%h ir=%b busy=%b required 1 %h 0 0", c, out_valid, prod, in_ready, busy, held);
      end
    end
    pp = mkpp(12'hFFB, 12'd7);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_swap: ov=%b busy=%b required 0 1", out_valid, busy);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4 || prod !== ref_mul(12'hFFB, 12'd7)) begin
      errors++;
      $display("FAIL bp_next: lat=%0d prod=%h required 4 %h", lat, prod, ref_mul(12'hFFB, 12'd7));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [23:0] p;
    pp = mkpp(12'h5A5, 12'h3C3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: ov=%b busy=%b ir=%b required 0 0 1", out_valid, busy, in_ready);
    end
    txn(12'hFF9, 12'd9, lat, p);
    checks++;
    if (lat !== 4 || p !== 24'hFFFFC1) begin
      errors++;
      $display("FAIL rst_next: lat=%0d prod=%h required 4 ffffc1", lat, p);
    end
  endtask

  task automatic test_random();
    logic [23:0] q [$];
    logic [11:0] a, b;
    logic pending = 1'b0;
    logic acc, ret;
    logic [23:0] seen;
    int sent = 0, got = 0, cyc = 0;
    localparam int N = 2000;
    while (got < N && cyc < 60000) begin
      if (!pending && sent < N && $urandom_range(0, 3) != 0) begin
        a = 12'($urandom);
        b = 12'($urandom);
        pp = mkpp(a, b);
        pending = 1'b1;
      end
      in_valid = pending;
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      seen = prod;
      tick();
      cyc++;
      if (ret) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: prod=%h required no output", seen);
        end else begin
          if (seen !== q[0]) begin
            errors++;
            $display("FAIL rand%0d: prod=%h required %h", got, seen, q[0]);
          end
          void'(q.pop_front());
        end
        got++;
      end
      if (acc) begin
        q.push_back(ref_mul(a, b));
        pending = 1'b0;
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== N || sent !== N || q.size() !== 0) begin
      errors++;
      $display("FAIL rand_count: got=%0d sent=%0d left=%0d required %0d %0d 0", got, sent, q.size(), N, N);
    end
    tick();
    tick();
  endtask

  task automatic test_sweep();
    int rl [5] = '{1, 2, 4, 6, 12};
    int lat [5];
    logic [23:0] res [5];
    logic [11:0] a, b;
    for (int t = 0; t < 3; t++) begin
      a = t == 0 ? 12'h800 : 12'($urandom);
      b = t == 0 ? 12'h7FF : 12'($urandom);
      for (int i = 0; i < 5; i++) lat[i] = -1;
      sw_pp = mkpp(a, b);
      sw_valid = 1'b1;
      tick();
      sw_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        if (c > 1 || rl[0] != 12) tick();
        for (int i = 0; i < 5; i++)
          if (sw_ov[i] && lat[i] < 0) begin
            lat[i] = c;
            res[i] = sw_prod[i];
          end
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (lat[i] !== 12 / rl[i] || res[i] !== ref_mul(a, b)) begin
          errors++;
          $display("FAIL sweep_rows%0d: lat=%0d prod=%h required %0d %h", rl[i], lat[i], res[i], 12 / rl[i], ref_mul(a, b));
        end
      end
      checks++;
      if (sw_busy !== 5'b0 || sw_ir !== 5'b11111) begin
        errors++;
        $display("FAIL sweep_idle: busy=%b ir=%b required 00000 11111", sw_busy, sw_ir);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
